spi_target_core: RTL
====================

// Module: spi_target_core
// PURPOSE
// - SPI responder (target) shift engine, counterpart of the SPI host: decodes host-driven SCK/CSB/SD0.
// - Returns one byte stream on SD1 while receiving another. Fully oversampled in clk_i domain; no SCK clocking.
// - Sits between the pads and a byte-wide TX/RX register or FIFO interface.
// PARAMETERS
// - DataWidth   8     bits per frame; counter width = prim_util_pkg::vbits(DataWidth)
// - SyncStages  2     synchronizer depth on spi_sck_i/spi_csb_i/spi_sd_i (>=2)
// - TxIdleByte  'hFF  word shifted out on TX underrun
// PORTS
// - clk_i        in   1          system clock; f_sck <= f_clk/(2*(SyncStages+2))
// - rst_i        in   1          synchronous, active-high reset
// - cpol_i       in   1          clock polarity; captured at CSB assertion
// - cpha_i       in   1          clock phase; captured at CSB assertion
// - msb_first_i  in   1          bit order; captured at CSB assertion
// - spi_sck_i    in   1          host SCK (async)
// - spi_csb_i    in   1          host chip select, active low (async)
// - spi_sd_i     in   1          host->target data (MOSI, async)
// - spi_sd_o     out  1          target->host data (MISO)
// - spi_sd_en_o  out  1          MISO output enable
// - tx_data_i    in   DataWidth  next byte to send
// - tx_valid_i   in   1          tx_data_i valid
// - tx_ready_o   out  1          1-cycle strobe: tx_data_i consumed
// - rx_data_o    out  DataWidth  last complete received byte
// - rx_valid_o   out  1          1-cycle strobe: rx_data_o updated; no back-pressure
// - tx_underrun_o out 1          1-cycle strobe: TxIdleByte loaded, tx_valid_i low
// - abort_o      out  1          1-cycle strobe: CSB deasserted mid-frame
// - done_o       out  1          1-cycle strobe: CSB deasserted (any)
// BEHAVIOUR
// - Reset values: spi_sd_o=0, spi_sd_en_o=0, rx_data_o=0; all strobes 0.
// - Reset values (cont.): synchronizer CSB=1, synchronizer SCK=0, FSM=WaitIdle.
// - Edge detect on synced SCK. leading = rise^cpol, trailing = the other edge.
// - Edge detect (cont.): sample edge = leading if cpha=0 else trailing; shift edge = the opposite edge.
// - FSM WaitIdle: leave to Idle only when synced CSB=1. A transfer already running at reset release is ignored.
// - FSM Idle: synced CSB fall -> Active. Same cycle: latch cpol/cpha/msb_first, bit_cnt=0, first=1, load TX word.
// - FSM Active, sample edge: rx_sr shifts in synced SD; bit_cnt++; first=0.
// - FSM Active, sample edge at bit_cnt==DataWidth-1: rx_data_o<=assembled word, rx_valid_o=1 next cycle, bit_cnt=0.
// - FSM Active, shift edge, bit_cnt!=0: tx_sr advances one bit.
// - FSM Active, shift edge, bit_cnt==0 and first=0: load next TX word (byte boundary).
// - FSM Active, shift edge, bit_cnt==0 and first=1: no action (cpha=1 preload already on line).
// - FSM Active -> Idle on synced CSB rise: done_o=1; abort_o=1 iff bit_cnt!=0.
// - CSB rise (cont.): partial RX bits discarded; consumed TX word lost.
// - Load TX word: tx_valid_i=1 -> tx_sr<=tx_data_i, tx_ready_o=1 (combinational on load cycle).
// - Load TX word (cont.): tx_valid_i=0 -> tx_sr<=TxIdleByte, tx_underrun_o=1.
// - spi_sd_o = tx_sr MSB if msb_first else LSB. RX assembles in the same order.
// - spi_sd_en_o = (FSM==Active).
// - Simultaneous events: CSB rise beats any SCK edge in the same cycle. No rx_valid_o on that cycle.
// - Latency: spi_sd_o changes SyncStages+1 clk_i after the shift edge at the pin.
// - Latency (cont.): rx_valid_o rises SyncStages+2 clk_i after the last sample edge.
// - Mode pins changing while Active have no effect.
// - rst_i mid-transfer -> WaitIdle; outputs return to reset values next cycle.
// STRUCTURE
// - spi_target_pkg: state_e {WaitIdle, Idle, Active}; edge_sel_t; BitCntW via prim_util_pkg::vbits.
// - Sub-module spi_target_sync_edge: SyncStages flops per input.
// - spi_target_sync_edge (cont.): sck_rise/sck_fall/csb_fall/csb_rise strobes and synced sd.
// - Top: FSM, bit counter, tx_sr/rx_sr.
// TESTING
// - Mode 0 MSB-first: host sends 0xA5, tx_data_i=0x3C valid -> MISO 0x3C, rx_data_o=0xA5, one rx_valid_o.
// - Mode 3 LSB-first: host sends 0x81, tx 0x42 -> MISO bits 0,1,0,0,0,0,1,0; rx_data_o=0x81.
// - tx_valid_i=0 at CSB fall and at byte 2 boundary -> 0xFF shifted both times, tx_underrun_o x2, tx_ready_o x0.
// - Back-to-back 2 bytes, mode 1, tx 0x12,0x34 -> MISO 0x12 then 0x34; rx_valid_o x2; tx_ready_o x2; done_o x1.
// - CSB raised after 3 SCK cycles -> abort_o=1, done_o=1, no rx_valid_o.
// - Abort case (cont.): next full 0x5A transfer received correctly.
// - rst_i pulse with CSB held low mid-byte -> no strobes until CSB high then low.
// - Reset case (cont.): then 0xC3 transfer completes normally.

Source files
------------

// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types, state encodings and helpers for the SPI target core
// Purpose: FSM state constants, SCK edge selector type, counter-width helper.
// Ports: none (package).
package spi_target_pkg;

   typedef logic [1:0] state_e;

   localparam state_e StWaitIdle = 2'd0;
   localparam state_e StIdle     = 2'd1;
   localparam state_e StActive   = 2'd2;

   typedef enum logic {
      EdgeRise = 1'b0,
      EdgeFall = 1'b1
   } edge_sel_t;

   // Bits needed to count 0..value-1, never less than one.
   function automatic int vbits(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   // Leading edge is the rise for cpol=0 and the fall for cpol=1; cpha=1 moves
   // sampling to the trailing edge. Both collapse to: sample on fall iff cpol^cpha.
   function automatic edge_sel_t sample_edge_sel(input logic cpol, input logic cpha);
      return edge_sel_t'(cpol ^ cpha);
   endfunction

endpackage

// File: rtl/spi_target_sync_edge.sv
// rtl/spi_target_sync_edge.sv - pad synchronizers and edge strobes for the SPI target
// Purpose: bring SCK/CSB/SD into the clk_i domain and flag their edges.
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   spi_sck_i/csb_i/sd_i  asynchronous pad inputs
//   csb_o, sd_o           synchronized CSB level and data bit
//   sck_rise_o/fall_o     one-cycle strobes on synchronized SCK edges
//   csb_fall_o/rise_o     one-cycle strobes on synchronized CSB edges
//   sync_ok_o             high once the chains hold genuine pad samples
module spi_target_sync_edge
   import spi_target_pkg::*;
#(
   parameter int SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic spi_sck_i,
   input  logic spi_csb_i,
   input  logic spi_sd_i,
   output logic csb_o,
   output logic sd_o,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic csb_fall_o,
   output logic csb_rise_o,
   output logic sync_ok_o
);

   logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
   logic [SyncStages-1:0] csb_sync_q, csb_sync_d;
   logic [SyncStages-1:0] sd_sync_q, sd_sync_d;
   logic                  sck_prev_q, sck_prev_d;
   logic                  csb_prev_q, csb_prev_d;
   // The CSB chain resets to 1 regardless of the pad, so the FSM must not
   // trust its level until the reset values have been flushed out.
   logic [SyncStages:0]   ok_q, ok_d;
   logic                  sck_s;

   always_comb begin
      sck_sync_d = {sck_sync_q[SyncStages-2:0], spi_sck_i};
      csb_sync_d = {csb_sync_q[SyncStages-2:0], spi_csb_i};
      sd_sync_d  = {sd_sync_q[SyncStages-2:0], spi_sd_i};
      sck_s      = sck_sync_q[SyncStages-1];
      csb_o      = csb_sync_q[SyncStages-1];
      sd_o       = sd_sync_q[SyncStages-1];
      sck_prev_d = sck_s;
      csb_prev_d = csb_o;
      ok_d       = {ok_q[SyncStages-1:0], 1'b1};
      sck_rise_o = sck_s & ~sck_prev_q;
      sck_fall_o = ~sck_s & sck_prev_q;
      csb_fall_o = ~csb_o & csb_prev_q;
      csb_rise_o = csb_o & ~csb_prev_q;
      sync_ok_o  = ok_q[SyncStages];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sck_sync_q <= '0;
         csb_sync_q <= '1;
         sd_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         csb_prev_q <= 1'b1;
         ok_q       <= '0;
      end else begin
         sck_sync_q <= sck_sync_d;
         csb_sync_q <= csb_sync_d;
         sd_sync_q  <= sd_sync_d;
         sck_prev_q <= sck_prev_d;
         csb_prev_q <= csb_prev_d;
         ok_q       <= ok_d;
      end
   end

endmodule

// File: rtl/spi_target_core.sv
// rtl/spi_target_core.sv - oversampled SPI target shift engine with byte-wide TX/RX handshake
// Purpose: receive a frame stream on spi_sd_i while returning tx_data_i words on spi_sd_o.
// Ports:
//   clk_i, rst_i                  system clock, synchronous active-high reset
//   cpol_i, cpha_i, msb_first_i   mode pins, captured when CSB asserts
//   spi_sck_i, spi_csb_i, spi_sd_i host pads (asynchronous)
//   spi_sd_o, spi_sd_en_o         MISO data and output enable
//   tx_data_i, tx_valid_i, tx_ready_o  TX word handshake (ready = consumed strobe)
//   rx_data_o, rx_valid_o         last received word and its update strobe
//   tx_underrun_o, abort_o, done_o event strobes
module spi_target_core
   import spi_target_pkg::*;
#(
   parameter int                   DataWidth  = 8,
   parameter int                   SyncStages = 2,
   parameter logic [DataWidth-1:0] TxIdleByte = DataWidth'('hFF)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpol_i,
   input  logic                 cpha_i,
   input  logic                 msb_first_i,
   input  logic                 spi_sck_i,
   input  logic                 spi_csb_i,
   input  logic                 spi_sd_i,
   output logic                 spi_sd_o,
   output logic                 spi_sd_en_o,
   input  logic [DataWidth-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic [DataWidth-1:0] rx_data_o,
   output logic                 rx_valid_o,
   output logic                 tx_underrun_o,
   output logic                 abort_o,
   output logic                 done_o
);

   localparam int                 BitCntW = vbits(DataWidth);
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DataWidth - 1);

   logic csb_s, sd_s, sck_rise, sck_fall, csb_fall, csb_rise, sync_ok;

   spi_target_sync_edge #(
      .SyncStages (SyncStages)
   ) u_sync_edge (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .spi_sck_i  (spi_sck_i),
      .spi_csb_i  (spi_csb_i),
      .spi_sd_i   (spi_sd_i),
      .csb_o      (csb_s),
      .sd_o       (sd_s),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .csb_fall_o (csb_fall),
      .csb_rise_o (csb_rise),
      .sync_ok_o  (sync_ok)
   );

   state_e               state_q, state_d;
   logic                 cpol_q, cpol_d;
   logic                 cpha_q, cpha_d;
   logic                 msb_q, msb_d;
   logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic                 first_q, first_d;
   logic [DataWidth-1:0] tx_sr_q, tx_sr_d;
   logic [DataWidth-1:0] rx_sr_q, rx_sr_d;
   logic [DataWidth-1:0] rx_data_q, rx_data_d;
   // rx_data_o updates on the cycle after the sample; the strobe follows one cycle later.
   logic                 rx_done_q, rx_done_d;
   logic                 rx_valid_q, rx_valid_d;

   logic                 load_tx;
   logic                 sample_evt, shift_evt;
   logic [DataWidth-1:0] rx_word;

   always_comb begin
      state_d       = state_q;
      cpol_d        = cpol_q;
      cpha_d        = cpha_q;
      msb_d         = msb_q;
      bit_cnt_d     = bit_cnt_q;
      first_d       = first_q;
      tx_sr_d       = tx_sr_q;
      rx_sr_d       = rx_sr_q;
      rx_data_d     = rx_data_q;
      rx_done_d     = 1'b0;
      rx_valid_d    = rx_done_q;
      load_tx       = 1'b0;
      tx_ready_o    = 1'b0;
      tx_underrun_o = 1'b0;
      abort_o       = 1'b0;
      done_o        = 1'b0;

      if (sample_edge_sel(cpol_q, cpha_q) == EdgeFall) begin
         sample_evt = sck_fall;
         shift_evt  = sck_rise;
      end else begin
         sample_evt = sck_rise;
         shift_evt  = sck_fall;
      end

      rx_word = msb_q ? {rx_sr_q[DataWidth-2:0], sd_s} : {sd_s, rx_sr_q[DataWidth-1:1]};

      case (state_q)
         StWaitIdle: begin
            // Never join a frame already in flight when reset released.
            if (sync_ok && csb_s) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (csb_fall) begin
               state_d   = StActive;
               cpol_d    = cpol_i;
               cpha_d    = cpha_i;
               msb_d     = msb_first_i;
               bit_cnt_d = '0;
               first_d   = 1'b1;
               load_tx   = 1'b1;
            end
         end
         StActive: begin
            // CSB release wins over any SCK edge seen in the same cycle.
            if (csb_rise) begin
               state_d   = StIdle;
               done_o    = 1'b1;
               abort_o   = (bit_cnt_q != '0);
               bit_cnt_d = '0;
            end else begin
               if (sample_evt) begin
                  rx_sr_d = rx_word;
                  first_d = 1'b0;
                  if (bit_cnt_q == LastBit) begin
                     rx_data_d = rx_word;
                     rx_done_d = 1'b1;
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BitCntW'(1);
                  end
               end
               if (shift_evt) begin
                  if (bit_cnt_q != '0) begin
                     tx_sr_d = msb_q ? (tx_sr_q << 1) : (tx_sr_q >> 1);
                  end else if (!first_q) begin
                     load_tx = 1'b1;
                  end
                  // bit_cnt==0 with first set: cpha=1 opening edge, word already on the line.
               end
            end
         end
         default: state_d = StWaitIdle;
      endcase

      if (load_tx) begin
         if (tx_valid_i) begin
            tx_sr_d    = tx_data_i;
            tx_ready_o = 1'b1;
         end else begin
            tx_sr_d       = TxIdleByte;
            tx_underrun_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StWaitIdle;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         msb_q      <= 1'b1;
         bit_cnt_q  <= '0;
         first_q    <= 1'b0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_done_q  <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         msb_q      <= msb_d;
         bit_cnt_q  <= bit_cnt_d;
         first_q    <= first_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_done_q  <= rx_done_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      spi_sd_en_o = (state_q == StActive);
      spi_sd_o    = spi_sd_en_o & (msb_q ? tx_sr_q[DataWidth-1] : tx_sr_q[0]);
      rx_data_o   = rx_data_q;
      rx_valid_o  = rx_valid_q;
   end

endmodule
